// File: rtl/regfile_param_if.sv
// Bundle of the register-bank access signals: write port, packed read ports,
// and the bulk-clear request/status lines.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [NRD*ADDR_W-1:0]  rd_addr;
    logic [NRD*DATA_W-1:0]  rd_data;
    logic                   clr_req;
    logic                   busy;
    logic                   clr_done;
    logic                   wr_drop;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, clr_req,
        input  rd_data, busy, clr_done, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
        output rd_data, busy, clr_done, wr_drop
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register bank with hardwired x0, optional
// write-to-read bypass and a sequential bulk-clear engine.
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_param_if.slave   bus,
    output logic [1:0]       dbg_state
);
    localparam int DEPTH = 1 << ADDR_W;

    // Timing contract: there is no valid/ready pair. A write is accepted on the
    // rising edge when wr_en is high, wr_addr != 0 and busy is low; otherwise it
    // is dropped (flagged by wr_drop a cycle later if busy caused it). Reads are
    // purely combinational and return 0 while busy. clr_req is sampled only in IDLE.

    if (NRD < 1 || NRD > 4) begin : g_nrd_check
        $error("regfile_param: NRD must be in 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                busy_c;
    logic                done_c;
    logic                wr_ok;
    logic                wr_drop_q;
    logic [ADDR_W-1:0]   ra;
    logic [NRD*DATA_W-1:0] rd_mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.clr_req) state_nx = S_CLEAR;
            S_CLEAR: if (cnt == '1)   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == S_CLEAR);
        done_c = (state == S_DONE);
    end

    assign bus.busy     = busy_c;
    assign bus.clr_done = done_c;
    assign bus.wr_drop  = wr_drop_q;
    assign dbg_state    = state;

    // The sweep starts at 1: x0 is hardwired and never needs clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE:  if (bus.clr_req) cnt <= ADDR_W'(1);
                S_CLEAR: cnt <= (cnt == '1) ? '0 : cnt + ADDR_W'(1);
                default: cnt <= '0;
            endcase
        end
    end

    assign wr_ok = bus.wr_en && (bus.wr_addr != '0) && !busy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (busy_c) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_drop_q <= 1'b0;
        else        wr_drop_q <= bus.wr_en && (bus.wr_addr != '0) && busy_c;
    end

    always_comb begin
        rd_mux = '0;
        ra     = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (!busy_c && ra != '0) begin
                if (BYPASS != 0 && bus.wr_en && bus.wr_addr == ra)
                    rd_mux[k*DATA_W +: DATA_W] = bus.wr_data;
                else
                    rd_mux[k*DATA_W +: DATA_W] = mem[ra];
            end
        end
    end

    assign bus.rd_data = rd_mux;
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: three instances (default with bypass,
// bypass disabled, narrow 16/3/3) checked through an expected-value scoreboard.
module tb_regfile_param;
    logic clk;
    logic rst_n;

    // shared stimulus for the two 32/5/2 instances
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic        clr_req;

    // stimulus for the 16/3/3 instance
    logic        c_wr_en;
    logic [2:0]  c_wr_addr;
    logic [15:0] c_wr_data;
    logic [8:0]  c_rd_addr;
    logic        c_clr_req;

    logic [1:0]  a_state;
    logic [1:0]  b_state;
    logic [1:0]  c_state;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_a ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_b ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3), .NRD(3)) if_c ();

    assign if_a.wr_en = wr_en;   assign if_a.wr_addr = wr_addr;  assign if_a.wr_data = wr_data;
    assign if_a.rd_addr = rd_addr; assign if_a.clr_req = clr_req;
    assign if_b.wr_en = wr_en;   assign if_b.wr_addr = wr_addr;  assign if_b.wr_data = wr_data;
    assign if_b.rd_addr = rd_addr; assign if_b.clr_req = clr_req;
    assign if_c.wr_en = c_wr_en; assign if_c.wr_addr = c_wr_addr; assign if_c.wr_data = c_wr_data;
    assign if_c.rd_addr = c_rd_addr; assign if_c.clr_req = c_clr_req;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state(a_state));
    regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state(b_state));
    regfile_param #(.DATA_W(16), .ADDR_W(3), .NRD(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c), .dbg_state(c_state));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int A_RD0 = 0,  A_RD1 = 1,  A_BUSY = 2,  A_DONE = 3,  A_DROP = 4;
    localparam int B_RD0 = 5,  C_RD0 = 6,  C_RD1 = 7,   C_RD2 = 8,   C_BUSY = 9;
    localparam int C_DONE = 10, C_DROP = 11, A_STATE = 12, B_STATE = 13, C_STATE = 14;

    // scoreboard
    logic [31:0] exp_q[$];
    int          sel_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mon_exp;
    logic [31:0] mon_obs;
    int          mon_sel;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            A_RD0:   return if_a.rd_data[31:0];
            A_RD1:   return if_a.rd_data[63:32];
            A_BUSY:  return {31'd0, if_a.busy};
            A_DONE:  return {31'd0, if_a.clr_done};
            A_DROP:  return {31'd0, if_a.wr_drop};
            B_RD0:   return if_b.rd_data[31:0];
            C_RD0:   return {16'd0, if_c.rd_data[15:0]};
            C_RD1:   return {16'd0, if_c.rd_data[31:16]};
            C_RD2:   return {16'd0, if_c.rd_data[47:32]};
            C_BUSY:  return {31'd0, if_c.busy};
            C_DONE:  return {31'd0, if_c.clr_done};
            C_DROP:  return {31'd0, if_c.wr_drop};
            A_STATE: return {30'd0, a_state};
            B_STATE: return {30'd0, b_state};
            C_STATE: return {30'd0, c_state};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic string sel_name(int sel);
        case (sel)
            A_RD0: return "a_rd0";   A_RD1: return "a_rd1";   A_BUSY: return "a_busy";
            A_DONE: return "a_clr_done"; A_DROP: return "a_wr_drop"; B_RD0: return "b_rd0";
            C_RD0: return "c_rd0";   C_RD1: return "c_rd1";   C_RD2: return "c_rd2";
            C_BUSY: return "c_busy"; C_DONE: return "c_clr_done"; C_DROP: return "c_wr_drop";
            A_STATE: return "a_state"; B_STATE: return "b_state"; C_STATE: return "c_state";
            default: return "unknown";
        endcase
    endfunction

    // monitor: every expectation pushed during a cycle is compared at its negedge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_sel = sel_q.pop_front();
            mon_obs = observe(mon_sel);
            n_checks++;
            if (mon_obs !== mon_exp) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h at %0t",
                         sel_name(mon_sel), mon_obs, mon_exp, $time);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int sel, input logic [31:0] v);
        exp_q.push_back(v);
        sel_q.push_back(sel);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; clr_req = 1'b0;
        c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_rd_addr = '0; c_clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_val(A_BUSY, 0); expect_val(A_DONE, 0); expect_val(A_DROP, 0);
        expect_val(A_RD0, 0);  expect_val(C_BUSY, 0); expect_val(A_STATE, 0);
        expect_val(B_STATE, 0);

        // x0 is hardwired, also when the write targets it
        step(); wr_en = 1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd0};
        expect_val(A_RD0, 0);
        step(); wr_en = 0;
        expect_val(A_DROP, 0); expect_val(A_RD0, 0);

        // plain write then read on both ports
        step(); wr_en = 1; wr_addr = 5'd5; wr_data = 32'h12345678;
        step(); wr_en = 0; rd_addr = {5'd5, 5'd5};
        expect_val(A_RD0, 32'h12345678); expect_val(A_RD1, 32'h12345678);
        expect_val(B_RD0, 32'h12345678);
        step(); wr_en = 1; wr_addr = 5'd31; wr_data = 32'hFFFFFFFF;
        step(); wr_en = 0; rd_addr = {5'd31, 5'd5};
        expect_val(A_RD0, 32'h12345678); expect_val(A_RD1, 32'hFFFFFFFF);

        // bypass: same-cycle write visible only on the BYPASS=1 instance
        step(); wr_en = 1; wr_addr = 5'd7; wr_data = 32'h1;
        step(); wr_en = 1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd5, 5'd7};
        expect_val(A_RD0, 32'hA5A5A5A5); expect_val(B_RD0, 32'h1);
        expect_val(A_RD1, 32'h12345678);
        step(); wr_en = 0;
        expect_val(A_RD0, 32'hA5A5A5A5); expect_val(B_RD0, 32'hA5A5A5A5);

        // asynchronous reset mid-cycle
        step(); rd_addr = {5'd31, 5'd5}; rst_n = 0;
        expect_val(A_RD0, 0); expect_val(A_RD1, 0); expect_val(B_RD0, 0);
        step(); rst_n = 1;
        expect_val(A_RD0, 0); expect_val(A_RD1, 0);

        // fill x1..x31 with their index
        for (int i = 1; i < 32; i++) begin
            step(); wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
        end
        step(); wr_en = 0; rd_addr = {5'd31, 5'd5};
        expect_val(A_RD0, 32'd5); expect_val(A_RD1, 32'd31);

        // bulk clear: 31 busy cycles, re-pulse and dropped writes inside
        step(); clr_req = 1;
        expect_val(A_BUSY, 0); expect_val(A_RD0, 32'd5);
        for (int c = 1; c <= 31; c++) begin
            step();
            clr_req = (c == 10);
            wr_en   = (c == 3) || (c == 6);
            wr_addr = (c == 3) ? 5'd3 : 5'd0;
            wr_data = 32'h33;
            expect_val(A_BUSY, 1); expect_val(A_DONE, 0); expect_val(A_RD0, 0);
            if (c == 1) expect_val(A_STATE, 1);
            if (c == 4) expect_val(A_DROP, 1);
            if (c == 7) expect_val(A_DROP, 0);
        end
        step(); wr_en = 0; clr_req = 1;
        expect_val(A_BUSY, 0); expect_val(A_DONE, 1); expect_val(A_STATE, 2);
        step(); clr_req = 0;
        expect_val(A_BUSY, 0); expect_val(A_DONE, 0);
        step(); rd_addr = {5'd3, 5'd31};
        expect_val(A_RD0, 0); expect_val(A_RD1, 0); expect_val(A_BUSY, 0);
        step(); rd_addr = {5'd1, 5'd5};
        expect_val(A_RD0, 0); expect_val(A_RD1, 0); expect_val(B_RD0, 0);

        // reset aborts a clear at cycle 10
        step(); wr_en = 1; wr_addr = 5'd2;  wr_data = 32'd2;
        step(); wr_en = 1; wr_addr = 5'd9;  wr_data = 32'd9;
        step(); wr_en = 1; wr_addr = 5'd30; wr_data = 32'd30;
        step(); wr_en = 0; clr_req = 1;
        for (int c = 1; c <= 9; c++) begin
            step(); clr_req = 0;
            expect_val(A_BUSY, 1);
        end
        step(); rst_n = 0;
        expect_val(A_BUSY, 0); expect_val(A_DONE, 0);
        step(); rst_n = 1; rd_addr = {5'd9, 5'd30};
        expect_val(A_RD0, 0); expect_val(A_RD1, 0); expect_val(A_BUSY, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            expect_val(A_DONE, 0); expect_val(A_BUSY, 0);
        end

        // narrow instance: 16-bit data, 8 registers, 3 read ports
        step(); c_wr_en = 1; c_wr_addr = 3'd6; c_wr_data = 16'hBEEF;
        step(); c_wr_en = 1; c_wr_addr = 3'd0; c_wr_data = 16'h1234; c_rd_addr = {3'd6, 3'd6, 3'd6};
        expect_val(C_RD0, 32'hBEEF); expect_val(C_RD1, 32'hBEEF); expect_val(C_RD2, 32'hBEEF);
        step(); c_wr_en = 0; c_rd_addr = {3'd0, 3'd6, 3'd0};
        expect_val(C_RD0, 0); expect_val(C_RD1, 32'hBEEF); expect_val(C_RD2, 0);
        expect_val(C_DROP, 0);
        step(); c_clr_req = 1;
        expect_val(C_BUSY, 0);
        for (int c = 1; c <= 7; c++) begin
            step(); c_clr_req = 0;
            expect_val(C_BUSY, 1); expect_val(C_DONE, 0);
        end
        step();
        expect_val(C_BUSY, 0); expect_val(C_DONE, 1); expect_val(C_STATE, 2);
        step();
        expect_val(C_DONE, 0); expect_val(C_RD1, 0);

        // let the monitor drain, then report
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised, multi-read-port register bank for the single-cycle CPU datapath.
- Generalised in data width, depth and read-port count, with a hardwired zero register and optional write-to-read bypass.
- Adds an async active-low reset and a sequential bulk-clear engine that zeroes the whole array without a reset.
- Sits between the decode stage (read addresses) and the writeback mux (write data).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = read returns same-cycle write data on address match; 0 = read returns array contents only.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable (RegWen).
- wr_addr  input  ADDR_W  write address (rd).
- wr_data  input  DATA_W  write data (wb_out).
- rd_addr  input  NRD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NRD*DATA_W  packed read data, same packing.
- clr_req  input  1  one-cycle request to start a bulk clear.
- busy  output  1  high while the clear engine runs.
- clr_done  output  1  one-cycle pulse when the clear completes.
- wr_drop  output  1  registered one-cycle pulse: a write was discarded because busy was high.

Behaviour:
- Reset (rst_n=0, async): all DEPTH registers = 0; FSM = IDLE; counter = 0; busy = 0, clr_done = 0, wr_drop = 0. Takes effect immediately, including mid-clear; the clear aborts.
- Write: on posedge clk, if wr_en && wr_addr != 0 && !busy, then reg[wr_addr] <= wr_data. New value is visible through the array the next cycle.
- Register 0: never written; always reads 0 on every port, regardless of bypass.
- Read (combinational, per port k):
  - If busy: 0.
  - Else if addr == 0: 0.
  - Else if BYPASS && wr_en && wr_addr == addr: wr_data.
  - Else: reg[addr].
  - All ports are independent; several ports may address the same register.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, counter <= 1, busy <= 1 on the same edge.
  - CLEAR: each cycle reg[counter] <= 0 and counter increments; when counter == DEPTH-1 (written this cycle) -> DONE. This gives exactly DEPTH-1 cycles in CLEAR.
  - DONE: busy <= 0, clr_done = 1 for this single cycle -> IDLE.
  - busy is registered: high from the cycle after clr_req is sampled through the last CLEAR cycle, and low in DONE.
  - clr_done is asserted only in DONE.
- clr_req while busy, or in DONE: ignored, no restart.
- clr_req and wr_en in the same IDLE cycle: the write completes (busy is still 0 that edge), and the clear then starts and zeroes it.
- wr_en && wr_addr != 0 while busy: write discarded; wr_drop = 1 on the next cycle. wr_en to address 0 never raises wr_drop.
- Counter width is ADDR_W; no wrap, because the exit occurs at DEPTH-1.
- Parameter check: NRD outside 1..4 raises an elaboration error.

Test Plan:
- Reset/zero: assert rst_n=0 mid-cycle -> every rd_data = 0 immediately. Then write x0 <= 0xDEADBEEF -> x0 reads 0, wr_drop = 0.
- Write/read: write x5 <= 0x12345678, then read port0 = 5, port1 = 5 next cycle -> both 0x12345678. Write x31 <= 0xFFFFFFFF -> reads back 0xFFFFFFFF.
- Bypass: BYPASS=1, x7 = 0x1, same cycle wr_en, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr0=7 -> rd_data0 = 0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> 0x1.
- Bulk clear: fill x1..x31 with their index values, pulse clr_req -> busy high for exactly 31 cycles, clr_done pulses once, and all reads then return 0. During busy, a write to x3 is dropped with wr_drop=1 and x3 reads 0 afterwards.
- Corner cases:
  - clr_req re-pulsed during CLEAR -> no extension; still 31 busy cycles.
  - rst_n asserted at CLEAR cycle 10 -> busy=0 immediately, no clr_done pulse, all registers 0.
- Parameter sweep: DATA_W=16, ADDR_W=3, NRD=3 -> clear takes 7 cycles; a write of 0xBEEF to x6 reads on all 3 ports; a write of 0x1234 to x0 is ignored.
